// File: rtl/controle_preparo_pkg.sv
// Shared definitions for the brew sequencer and the pump controller.
package controle_preparo_pkg;

  localparam int unsigned W_ESTADO = 4;
  localparam int unsigned W_COD    = 3;
  localparam int unsigned W_MODO   = 2;

  // Sequencer states; the encoding is exported on db_estado for the 7-seg debug display
  typedef enum logic [W_ESTADO-1:0] {
    OCIOSO   = 4'd0,
    VERIFICA = 4'd1,
    AQUECE   = 4'd2,
    DISPARA  = 4'd3,
    BOMBEIA  = 4'd4,
    FIM      = 4'd5,
    ERRO     = 4'd6
  } estado_t;

  // Error codes reported on cod_erro while in ERRO
  typedef enum logic [W_COD-1:0] {
    COD_NENHUM    = 3'd0,
    COD_MODO      = 3'd1,
    COD_COPO      = 3'd2,
    COD_AGUA      = 3'd3,
    COD_AQUECE    = 3'd4,
    COD_BOMBA     = 3'd5,
    COD_CANCELADO = 3'd6
  } cod_erro_t;

  localparam logic [W_MODO-1:0] MODO_PEQUENO = 2'b01;
  localparam logic [W_MODO-1:0] MODO_GRANDE  = 2'b10;

  // Only the two cup sizes are legal brew modes
  function automatic logic modo_valido(input logic [W_MODO-1:0] m);
    return (m == MODO_PEQUENO) || (m == MODO_GRANDE);
  endfunction

endpackage

// File: rtl/controle_preparo_if.sv
// Signals between the UI side (master) and the brew sequencer (slave).
interface controle_preparo_if;
  import controle_preparo_pkg::*;

  logic                iniciar;
  logic                cancelar;
  logic [W_MODO-1:0]   modo;
  logic                copo_presente;
  logic                nivel_ok;
  logic                temp_ok;
  logic                fim_bomba;
  logic                liga_bomba;
  logic [W_MODO-1:0]   modo_bomba;
  logic                aquecedor;
  logic                ocupado;
  logic                pronto;
  logic                erro;
  logic [W_COD-1:0]    cod_erro;
  logic [W_ESTADO-1:0] db_estado;

  modport master (
    output iniciar, cancelar, modo, copo_presente, nivel_ok, temp_ok, fim_bomba,
    input  liga_bomba, modo_bomba, aquecedor, ocupado, pronto, erro, cod_erro, db_estado
  );

  modport slave (
    input  iniciar, cancelar, modo, copo_presente, nivel_ok, temp_ok, fim_bomba,
    output liga_bomba, modo_bomba, aquecedor, ocupado, pronto, erro, cod_erro, db_estado
  );

endinterface

// File: rtl/controle_preparo_contador_m.sv
// Saturating timeout counter: zera_s_i clears, conta_i runs, fim_o flags count == LIMITE.
module contador_m #(
  parameter int unsigned NT     = 31,
  parameter int unsigned LIMITE = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_s_i,
  input  logic conta_i,
  output logic fim_o
);

  logic [NT-1:0] cnt_q, cnt_d;
  logic          fim_q;

  // Next count: clear wins, otherwise count up and stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (zera_s_i) begin
      cnt_d = '0;
    end else if (conta_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + NT'(1);
    end
  end

  // fim is registered against the next count so it lines up with the cycle holding LIMITE
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      fim_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fim_q <= (cnt_d == NT'(LIMITE));
    end
  end

  assign fim_o = fim_q;

endmodule

// File: rtl/controle_preparo.sv
// Brew sequencer: validates the request, heats, fires the pump and reports done/error.
module controle_preparo
  import controle_preparo_pkg::*;
#(
  parameter int unsigned T_AQUECE_MAX = 1500000000,
  parameter int unsigned T_BOMBA_MAX  = 750000000,
  parameter int unsigned NT           = 31
) (
  input  logic               clock,
  input  logic               reset,
  controle_preparo_if.slave  bus
);

  estado_t           estado_q, estado_d;
  cod_erro_t         cod_q, cod_d;
  logic [W_MODO-1:0] modo_q;
  logic              liga_q, aquec_q, ocup_q, pronto_q, erro_q;
  logic              fim_aquece, fim_bombeia;

  // Heater timeout: cleared in VERIFICA, runs through AQUECE
  contador_m #(.NT(NT), .LIMITE(T_AQUECE_MAX - 1)) u_cont_aquece (
    .clock    (clock),
    .reset    (reset),
    .zera_s_i (estado_q == VERIFICA),
    .conta_i  (estado_q == AQUECE),
    .fim_o    (fim_aquece)
  );

  // Pump watchdog: cleared in DISPARA, runs through BOMBEIA
  contador_m #(.NT(NT), .LIMITE(T_BOMBA_MAX - 1)) u_cont_bomba (
    .clock    (clock),
    .reset    (reset),
    .zera_s_i (estado_q == DISPARA),
    .conta_i  (estado_q == BOMBEIA),
    .fim_o    (fim_bombeia)
  );

  // Next state and error code; cod_erro is non-zero only while sitting in ERRO
  always_comb begin
    estado_d = estado_q;
    cod_d    = COD_NENHUM;
    case (estado_q)
      OCIOSO: begin
        if (bus.iniciar) estado_d = VERIFICA;
      end
      VERIFICA: begin
        if (!modo_valido(modo_q)) begin
          estado_d = ERRO; cod_d = COD_MODO;
        end else if (!bus.copo_presente) begin
          estado_d = ERRO; cod_d = COD_COPO;
        end else if (!bus.nivel_ok) begin
          estado_d = ERRO; cod_d = COD_AGUA;
        end else begin
          estado_d = AQUECE;
        end
      end
      AQUECE: begin
        if (bus.cancelar) begin
          estado_d = ERRO; cod_d = COD_CANCELADO;
        end else if (!bus.copo_presente) begin
          estado_d = ERRO; cod_d = COD_COPO;
        end else if (fim_aquece) begin
          estado_d = ERRO; cod_d = COD_AQUECE;
        end else if (bus.temp_ok) begin
          estado_d = DISPARA;
        end
      end
      DISPARA: estado_d = BOMBEIA;
      BOMBEIA: begin
        // Pump run cannot be aborted: cancel and cup removal are not looked at here
        if (bus.fim_bomba) begin
          estado_d = FIM;
        end else if (fim_bombeia) begin
          estado_d = ERRO; cod_d = COD_BOMBA;
        end
      end
      FIM: estado_d = OCIOSO;
      ERRO: begin
        // Acknowledge returns to idle without starting a new cycle
        if (bus.iniciar && !bus.cancelar) begin
          estado_d = OCIOSO;
        end else begin
          cod_d = cod_q;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State register with Moore outputs decoded from the next state so they are registered
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cod_q    <= COD_NENHUM;
      modo_q   <= '0;
      liga_q   <= 1'b0;
      aquec_q  <= 1'b0;
      ocup_q   <= 1'b0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cod_q    <= cod_d;
      liga_q   <= (estado_d == DISPARA);
      aquec_q  <= (estado_d inside {AQUECE, DISPARA, BOMBEIA});
      ocup_q   <= (estado_d inside {VERIFICA, AQUECE, DISPARA, BOMBEIA});
      pronto_q <= (estado_d == FIM);
      erro_q   <= (estado_d == ERRO);
      if ((estado_q == OCIOSO) && bus.iniciar) modo_q <= bus.modo;
    end
  end

  assign bus.liga_bomba = liga_q;
  assign bus.modo_bomba = modo_q;
  assign bus.aquecedor  = aquec_q;
  assign bus.ocupado    = ocup_q;
  assign bus.pronto     = pronto_q;
  assign bus.erro       = erro_q;
  assign bus.cod_erro   = cod_q;
  assign bus.db_estado  = estado_q;

endmodule

// File: tb/tb_controle_preparo.sv
// Bench for controle_preparo: directed and random brew cycles against a timeline model.
module tb_controle_preparo;

  localparam int unsigned T_AQ  = 20;
  localparam int unsigned T_BB  = 30;
  localparam int unsigned NT    = 31;
  localparam int          JANELA = 60;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  controle_preparo_if bus();

  controle_preparo #(.T_AQUECE_MAX(T_AQ), .T_BOMBA_MAX(T_BB), .NT(NT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // One clock; outputs are sampled 1 time unit after the edge
  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic zera_entradas();
    bus.iniciar       = 1'b0;
    bus.cancelar      = 1'b0;
    bus.modo          = 2'b00;
    bus.copo_presente = 1'b1;
    bus.nivel_ok      = 1'b1;
    bus.temp_ok       = 1'b0;
    bus.fim_bomba     = 1'b0;
  endtask

  // Runs one request. Timeline: iniciar in cycle 0, VERIFICA seen at o=1, AQUECE from o=2 (AQUECE
  // cycle k is drive cycle k+2). Pump model answers fim_bomba 10 clocks after liga_bomba.
  task automatic run_ciclo(input logic [1:0] modo, input bit cup, input bit nivel,
                           input int t_temp, input int t_cancel, input int t_cupout,
                           input bit supress, input bit cancel_pump, input string nome);
    int exp_cod, exp_erro_o, exp_liga_o, exp_pronto_o, exp_heat;
    int m_cod, m_erro_o, m_liga_o, m_liga_n, m_pronto_o, m_pronto_n, m_heat, fim_at, o, k;
    logic [1:0] m_modo;
    bit achou;

    exp_cod = 0; exp_erro_o = -1; exp_liga_o = -1; exp_pronto_o = -1; exp_heat = 0;
    if (modo != 2'b01 && modo != 2'b10) begin
      exp_cod = 1; exp_erro_o = 2;
    end else if (!cup) begin
      exp_cod = 2; exp_erro_o = 2;
    end else if (!nivel) begin
      exp_cod = 3; exp_erro_o = 2;
    end else begin
      achou = 1'b0;
      for (int kk = 0; kk < int'(T_AQ) && !achou; kk++) begin
        if (t_cancel >= 0 && kk == t_cancel) exp_cod = 6;
        else if (t_cupout >= 0 && kk >= t_cupout) exp_cod = 2;
        else if (kk == int'(T_AQ) - 1) exp_cod = 4;
        else if (kk >= t_temp) begin
          exp_liga_o = kk + 3; achou = 1'b1;
        end
        if (exp_cod != 0) begin
          exp_erro_o = kk + 3; exp_heat = kk + 1; achou = 1'b1;
        end
      end
      if (exp_liga_o >= 0) begin
        if (supress) begin
          exp_cod = 5; exp_erro_o = exp_liga_o + int'(T_BB) + 1; exp_heat = exp_liga_o + int'(T_BB) - 1;
        end else begin
          exp_pronto_o = exp_liga_o + 11; exp_heat = exp_liga_o + 9;
        end
      end
    end

    m_cod = 0; m_erro_o = -1; m_liga_o = -1; m_liga_n = 0; m_pronto_o = -1; m_pronto_n = 0;
    m_heat = 0; fim_at = -1; m_modo = 2'b00;
    for (int c = 0; c < JANELA; c++) begin
      k = c - 2;
      bus.iniciar       = (c == 0);
      bus.modo          = (c <= 1) ? modo : 2'($urandom);
      bus.nivel_ok      = nivel;
      bus.copo_presente = (c <= 1) ? cup : (cup && !(t_cupout >= 0 && k >= t_cupout));
      bus.temp_ok       = (k >= 0 && k >= t_temp);
      bus.cancelar      = (t_cancel >= 0 && k == t_cancel) ||
                          (cancel_pump && m_liga_o >= 0 && c >= m_liga_o + 2 && c <= m_liga_o + 6);
      bus.fim_bomba     = !supress && (c == fim_at);
      ciclo();
      o = c + 1;
      if (bus.liga_bomba) begin
        m_liga_n++;
        if (m_liga_o < 0) begin
          m_liga_o = o; m_modo = bus.modo_bomba; fim_at = o + 10;
        end
      end
      if (bus.pronto) begin
        m_pronto_n++;
        if (m_pronto_o < 0) m_pronto_o = o;
      end
      if (bus.erro && m_erro_o < 0) begin
        m_erro_o = o; m_cod = int'(bus.cod_erro);
      end
      if (bus.aquecedor) m_heat++;
      if (!bus.erro) begin
        total++;
        if (bus.cod_erro !== 3'd0) begin
          bad++; $display("FAIL %s cod_zero o=%0d: got %0d want 0", nome, o, bus.cod_erro);
        end
      end
      if (m_liga_o >= 0 && bus.ocupado) begin
        total++;
        if (bus.modo_bomba !== modo) begin
          bad++; $display("FAIL %s modo_estavel o=%0d: got %b want %b", nome, o, bus.modo_bomba, modo);
        end
      end
    end
    zera_entradas();

    total++;
    if (m_erro_o !== exp_erro_o) begin
      bad++; $display("FAIL %s erro_ciclo: got %0d want %0d", nome, m_erro_o, exp_erro_o);
    end
    total++;
    if (m_cod !== exp_cod) begin
      bad++; $display("FAIL %s cod_erro: got %0d want %0d", nome, m_cod, exp_cod);
    end
    total++;
    if (m_liga_n !== ((exp_liga_o >= 0) ? 1 : 0) || m_liga_o !== exp_liga_o) begin
      bad++; $display("FAIL %s liga_bomba: got n=%0d o=%0d want o=%0d", nome, m_liga_n, m_liga_o, exp_liga_o);
    end
    total++;
    if (m_pronto_n !== ((exp_pronto_o >= 0) ? 1 : 0) || m_pronto_o !== exp_pronto_o) begin
      bad++; $display("FAIL %s pronto: got n=%0d o=%0d want o=%0d", nome, m_pronto_n, m_pronto_o, exp_pronto_o);
    end
    total++;
    if (m_heat !== exp_heat) begin
      bad++; $display("FAIL %s aquecedor_ciclos: got %0d want %0d", nome, m_heat, exp_heat);
    end
    if (exp_liga_o >= 0) begin
      total++;
      if (m_modo !== modo) begin
        bad++; $display("FAIL %s modo_bomba: got %b want %b", nome, m_modo, modo);
      end
    end
    total++;
    if (bus.ocupado !== 1'b0 || bus.erro !== (exp_cod != 0)) begin
      bad++; $display("FAIL %s estado_final: got ocupado=%b erro=%b want 0/%0b", nome, bus.ocupado, bus.erro, exp_cod != 0);
    end

    // Acknowledge: iniciar with cancelar held is refused, a clean iniciar returns to idle only
    if (exp_cod != 0) begin
      bus.iniciar = 1'b1; bus.cancelar = 1'b1;
      ciclo();
      total++;
      if (bus.erro !== 1'b1 || bus.cod_erro !== 3'(exp_cod)) begin
        bad++; $display("FAIL %s ack_com_cancelar: got erro=%b cod=%0d want 1/%0d", nome, bus.erro, bus.cod_erro, exp_cod);
      end
      bus.cancelar = 1'b0;
      ciclo();
      bus.iniciar = 1'b0;
      total++;
      if (bus.erro !== 1'b0 || bus.cod_erro !== 3'd0) begin
        bad++; $display("FAIL %s ack: got erro=%b cod=%0d want 0/0", nome, bus.erro, bus.cod_erro);
      end
      for (int i = 0; i < 3; i++) begin
        ciclo();
        total++;
        if (bus.ocupado !== 1'b0 || bus.liga_bomba !== 1'b0) begin
          bad++; $display("FAIL %s ack_sem_ciclo: got ocupado=%b liga=%b want 0/0", nome, bus.ocupado, bus.liga_bomba);
        end
      end
    end
    ciclo();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    zera_entradas();
    repeat (3) ciclo();
    total++;
    if ({bus.liga_bomba, bus.modo_bomba, bus.aquecedor, bus.ocupado, bus.pronto, bus.erro,
         bus.cod_erro, bus.db_estado} !== 15'd0) begin
      bad++; $display("FAIL reset saidas: got liga=%b modo=%b aq=%b oc=%b pr=%b er=%b cod=%0d est=%0d want all 0",
                      bus.liga_bomba, bus.modo_bomba, bus.aquecedor, bus.ocupado, bus.pronto, bus.erro,
                      bus.cod_erro, bus.db_estado);
    end
    reset = 1'b0;
    ciclo();
    total++;
    if (bus.ocupado !== 1'b0 || bus.db_estado !== 4'd0) begin
      bad++; $display("FAIL reset ocioso: got ocupado=%b est=%0d want 0/0", bus.ocupado, bus.db_estado);
    end
  endtask

  task automatic test_normal();
    run_ciclo(2'b01, 1, 1, 5, -1, -1, 0, 0, "normal_pequeno");
    run_ciclo(2'b10, 1, 1, 0, -1, -1, 0, 0, "temp_ja_ok");
    run_ciclo(2'b10, 1, 1, 18, -1, -1, 0, 0, "temp_limite");
  endtask

  task automatic test_validacao();
    run_ciclo(2'b11, 1, 1, 0, -1, -1, 0, 0, "modo_11");
    run_ciclo(2'b00, 1, 1, 0, -1, -1, 0, 0, "modo_00");
    run_ciclo(2'b10, 0, 1, 0, -1, -1, 0, 0, "sem_copo");
    run_ciclo(2'b10, 1, 0, 0, -1, -1, 0, 0, "sem_agua");
    run_ciclo(2'b11, 0, 0, 0, -1, -1, 0, 0, "prioridade_modo");
  endtask

  task automatic test_timeout_aquece();
    run_ciclo(2'b01, 1, 1, 1000, -1, -1, 0, 0, "timeout_aquece");
    run_ciclo(2'b01, 1, 1, 19, -1, -1, 0, 0, "timeout_vs_temp");
  endtask

  task automatic test_watchdog();
    run_ciclo(2'b10, 1, 1, 2, -1, -1, 1, 1, "watchdog_cancel_ignorado");
    run_ciclo(2'b01, 1, 1, 4, -1, 7, 0, 1, "bomba_ignora_copo_cancel");
  endtask

  task automatic test_cancel_copo();
    run_ciclo(2'b01, 1, 1, 1000, 3, -1, 0, 0, "cancelar_aquece");
    run_ciclo(2'b01, 1, 1, 1000, -1, 4, 0, 0, "copo_sai_aquece");
    run_ciclo(2'b10, 1, 1, 6, 6, 6, 0, 0, "cancel_vence_copo");
    run_ciclo(2'b10, 1, 1, 1000, -1, 19, 0, 0, "copo_vence_timeout");
    run_ciclo(2'b01, 1, 1, 0, 0, -1, 0, 0, "cancel_vence_temp");
  endtask

  task automatic test_reset_meio();
    int   vistos;
    logic ok;
    // Reset while pumping
    zera_entradas();
    bus.modo = 2'b01; bus.iniciar = 1'b1;
    ciclo();
    bus.iniciar = 1'b0; bus.temp_ok = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ciclo();
      if (bus.liga_bomba) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL reset_bombeia liga_ausente: got 0 want 1");
    end
    repeat (3) ciclo();
    total++;
    if (bus.aquecedor !== 1'b1) begin
      bad++; $display("FAIL reset_bombeia pre: got aquecedor=%b want 1", bus.aquecedor);
    end
    reset = 1'b1;
    ciclo();
    reset = 1'b0;
    bus.temp_ok = 1'b0;
    total++;
    if ({bus.liga_bomba, bus.modo_bomba, bus.aquecedor, bus.ocupado, bus.pronto, bus.erro, bus.cod_erro} !== 10'd0) begin
      bad++; $display("FAIL reset_bombeia saidas: got aq=%b oc=%b modo=%b want all 0", bus.aquecedor, bus.ocupado, bus.modo_bomba);
    end
    // Reset while heating
    bus.modo = 2'b10; bus.iniciar = 1'b1;
    ciclo();
    bus.iniciar = 1'b0;
    repeat (5) ciclo();
    total++;
    if (bus.aquecedor !== 1'b1) begin
      bad++; $display("FAIL reset_aquece pre: got aquecedor=%b want 1", bus.aquecedor);
    end
    reset = 1'b1;
    ciclo();
    reset = 1'b0;
    total++;
    if ({bus.liga_bomba, bus.modo_bomba, bus.aquecedor, bus.ocupado, bus.pronto, bus.erro, bus.cod_erro} !== 10'd0) begin
      bad++; $display("FAIL reset_aquece saidas: got aq=%b oc=%b modo=%b want all 0", bus.aquecedor, bus.ocupado, bus.modo_bomba);
    end
    vistos = 0;
    for (int i = 0; i < 4; i++) begin
      ciclo();
      if (bus.ocupado) vistos++;
    end
    total++;
    if (vistos !== 0) begin
      bad++; $display("FAIL reset_aquece fica_ocioso: got %0d busy cycles want 0", vistos);
    end
  endtask

  task automatic test_fim_perdido();
    int n_pronto;
    zera_entradas();
    bus.fim_bomba = 1'b1;
    ciclo();
    bus.fim_bomba = 1'b0;
    n_pronto = bus.pronto ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      ciclo();
      if (bus.pronto || bus.ocupado) n_pronto++;
    end
    total++;
    if (n_pronto !== 0) begin
      bad++; $display("FAIL fim_perdido: got %0d pronto/busy cycles want 0", n_pronto);
    end
  endtask

  task automatic test_aleatorio();
    logic [1:0] modo;
    int r, t_temp, t_cancel, t_cupout;
    bit cup, nivel, supress, cancel_pump;
    for (int i = 0; i < 14; i++) begin
      r = int'($urandom_range(0, 7));
      modo = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r == 6) ? 2'b00 : 2'b11;
      cup         = ($urandom_range(0, 9) != 0);
      nivel       = ($urandom_range(0, 9) != 0);
      t_temp      = int'($urandom_range(0, 24));
      t_cancel    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 22)) : -1;
      t_cupout    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 22)) : -1;
      supress     = ($urandom_range(0, 4) == 0);
      cancel_pump = ($urandom_range(0, 1) == 1);
      run_ciclo(modo, cup, nivel, t_temp, t_cancel, t_cupout, supress, cancel_pump, $sformatf("aleatorio_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_validacao();
    test_timeout_aquece();
    test_watchdog();
    test_cancel_copo();
    test_reset_meio();
    test_fim_perdido();
    test_aleatorio();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
